contador_param_mais_menos: RTL and testbench

- Parametrised saturating/wrapping up-down counter for operator level selection (e.g. drone throttle/speed level) driven by raw soma/sub button levels.
- Generalises the 2-bit ±1 counter:
  - configurable width, bounds and step;
  - runtime wrap mode;
  - single-step-per-press edge detection with optional auto-repeat while held;
  - min/max flags and a limit pulse.
- Sits between the button synchronisers and the level-to-PWM mapping logic.

---
 rtl/contador_pkg.sv | 23 ++
 rtl/contador_press_fsm.sv | 128 ++++++++++++
 rtl/contador_param_mais_menos.sv | 107 ++++++++++
 tb/tb_contador_param_mais_menos.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and the clamp-into-bounds helper for the up/down level counter.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

  function automatic int unsigned clamp_val(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/contador_press_fsm.sv
// Button edge detect plus press FSM; emits one-cycle step_up/step_dn pulses.
// Auto-repeat timing exists only when CONTADOR_AUTO_REPEAT_EN is defined.
module contador_press_fsm
  import contador_pkg::*;
`ifdef CONTADOR_AUTO_REPEAT_EN
#(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
)
`endif
(
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_ld_n,
  input  logic i_enp,
  input  logic i_soma,
  input  logic i_sub,
  output logic o_step_up,
  output logic o_step_dn
);

  logic   r_soma_q, r_sub_q;
  state_t r_state, w_state_nxt;
  dir_t   r_dir, w_dir_nxt;
  logic   w_run, w_rise_up, w_rise_dn, w_press_up, w_press_dn;
  logic   w_dir_btn, w_opp_btn, w_exit;

  assign w_run      = i_clr_n & i_ld_n;
  assign w_rise_up  = i_soma & ~r_soma_q;
  assign w_rise_dn  = i_sub & ~r_sub_q;
  assign w_press_up = i_enp & w_rise_up & ~w_rise_dn;
  assign w_press_dn = i_enp & w_rise_dn & ~w_rise_up;
  assign w_dir_btn  = (r_dir == UP) ? i_soma : i_sub;
  assign w_opp_btn  = (r_dir == UP) ? i_sub : i_soma;
  assign w_exit     = ~w_dir_btn | w_opp_btn | ~i_enp;

`ifdef CONTADOR_AUTO_REPEAT_EN
  localparam int unsigned T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          w_timer_hit;

  assign w_timer_hit = (r_state == HOLD) ? (r_timer == HOLD_LAST) : (r_timer == REPEAT_LAST);
`endif

  // Edge registers track the buttons even through clear/load, so a held button never steps.
  always_ff @(posedge i_clk) begin
    r_soma_q <= i_soma;
    r_sub_q  <= i_sub;
    if (!w_run) begin
      r_state <= IDLE;
      r_dir   <= UP;
`ifdef CONTADOR_AUTO_REPEAT_EN
      r_timer <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
`ifdef CONTADOR_AUTO_REPEAT_EN
      r_timer <= w_timer_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
`ifdef CONTADOR_AUTO_REPEAT_EN
    w_timer_nxt = '0;
`endif
    case (r_state)
      IDLE: begin
        if (w_press_up) begin
          w_state_nxt = HOLD;
          w_dir_nxt   = UP;
        end else if (w_press_dn) begin
          w_state_nxt = HOLD;
          w_dir_nxt   = DN;
        end
      end
`ifdef CONTADOR_AUTO_REPEAT_EN
      HOLD, REPEAT: begin
        if (w_exit) begin
          w_state_nxt = IDLE;
        end else if (w_timer_hit) begin
          w_state_nxt = REPEAT;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
`else
      HOLD: begin
        if (w_exit) w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_step_up = 1'b0;
    o_step_dn = 1'b0;
    if (w_run) begin
      case (r_state)
        IDLE: begin
          o_step_up = w_press_up;
          o_step_dn = w_press_dn;
        end
`ifdef CONTADOR_AUTO_REPEAT_EN
        HOLD, REPEAT: begin
          if (!w_exit && w_timer_hit) begin
            o_step_up = (r_dir == UP);
            o_step_dn = (r_dir == DN);
          end
        end
`endif
        default: begin
          o_step_up = 1'b0;
          o_step_dn = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/contador_param_mais_menos.sv
// Parametrised saturating/wrapping up-down level counter driven by soma/sub buttons.
// Optional auto-repeat while held: define CONTADOR_AUTO_REPEAT_EN.
module contador_param_mais_menos
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 3,
  parameter int unsigned STEP          = 1,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
)
(
  input  logic             clock,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  input  logic             enp,
  input  logic             soma,
  input  logic             sub,
  input  logic             wrap,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             at_min,
  output logic             at_max,
  output logic             lim
);

  localparam int unsigned     WE     = WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_Q  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_E = WE'(STEP);

  if (MAX_VAL < MIN_VAL || longint'(MAX_VAL) >= (longint'(1) << WIDTH) || STEP == 0 ||
      HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_param_err
    $error("contador_param_mais_menos: illegal parameter set");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_lim;
  logic             w_step_up, w_step_dn, w_at_min, w_at_max;
  logic [WIDTH:0]   w_q_ext, w_up_raw, w_dn_raw;
  logic [WIDTH-1:0] w_up_val, w_dn_val, w_ld_val;

  contador_press_fsm
`ifdef CONTADOR_AUTO_REPEAT_EN
  #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  )
`endif
  u_press (
    .i_clk     (clock),
    .i_clr_n   (clr),
    .i_ld_n    (ld),
    .i_enp     (enp),
    .i_soma    (soma),
    .i_sub     (sub),
    .o_step_up (w_step_up),
    .o_step_dn (w_step_dn)
  );

  // One extra bit keeps Q+STEP from overflowing; the down path floors at zero before clamping.
  assign w_q_ext  = {1'b0, r_q};
  assign w_up_raw = w_q_ext + STEP_E;
  assign w_dn_raw = (w_q_ext >= STEP_E) ? (w_q_ext - STEP_E) : '0;
  assign w_up_val = WIDTH'(clamp_val(32'(w_up_raw), MIN_VAL, MAX_VAL));
  assign w_dn_val = WIDTH'(clamp_val(32'(w_dn_raw), MIN_VAL, MAX_VAL));
  assign w_ld_val = WIDTH'(clamp_val(32'(D), MIN_VAL, MAX_VAL));

  assign w_at_min = (r_q == MIN_Q);
  assign w_at_max = (r_q == MAX_Q);

  always_ff @(posedge clock) begin
    if (!clr) begin
      r_q   <= MIN_Q;
      r_lim <= 1'b0;
    end else if (!ld) begin
      r_q   <= w_ld_val;
      r_lim <= 1'b0;
    end else begin
      r_lim <= 1'b0;
      if (w_step_up) begin
        if (w_at_max) begin
          r_lim <= 1'b1;
          if (wrap) r_q <= MIN_Q;
        end else begin
          r_q <= w_up_val;
        end
      end else if (w_step_dn) begin
        if (w_at_min) begin
          r_lim <= 1'b1;
          if (wrap) r_q <= MAX_Q;
        end else begin
          r_q <= w_dn_val;
        end
      end
    end
  end

  assign Q      = r_q;
  assign lim    = r_lim;
  assign at_min = w_at_min;
  assign at_max = w_at_max;
  assign rco    = enp & w_at_min;

endmodule

// File: tb/tb_contador_param_mais_menos.sv
// Directed bench for contador_param_mais_menos: three instances with different bounds/steps.
`timescale 1ns/1ps
module tb_contador_param_mais_menos;

  logic       clk = 1'b0;
  logic       clr, ld, enp, soma, sub, wrap;
  logic [3:0] d;

  logic [1:0] q_a;
  logic [3:0] q_b, q_c;
  logic       rco_a, min_a, max_a, lim_a;
  logic       rco_b, min_b, max_b, lim_b;
  logic       rco_c, min_c, max_c, lim_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  contador_param_mais_menos #(
    .WIDTH(2), .MIN_VAL(0), .MAX_VAL(3), .STEP(1), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
  ) u_dut_a (
    .clock(clk), .clr(clr), .ld(ld), .D(d[1:0]), .enp(enp), .soma(soma), .sub(sub),
    .wrap(wrap), .Q(q_a), .rco(rco_a), .at_min(min_a), .at_max(max_a), .lim(lim_a)
  );

  contador_param_mais_menos #(
    .WIDTH(4), .MIN_VAL(2), .MAX_VAL(9), .STEP(3), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
  ) u_dut_b (
    .clock(clk), .clr(clr), .ld(ld), .D(d), .enp(enp), .soma(soma), .sub(sub),
    .wrap(wrap), .Q(q_b), .rco(rco_b), .at_min(min_b), .at_max(max_b), .lim(lim_b)
  );

  contador_param_mais_menos #(
    .WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .STEP(1), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
  ) u_dut_c (
    .clock(clk), .clr(clr), .ld(ld), .D(d), .enp(enp), .soma(soma), .sub(sub),
    .wrap(wrap), .Q(q_c), .rco(rco_c), .at_min(min_c), .at_max(max_c), .lim(lim_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0; ld = 1'b1; soma = 1'b0; sub = 1'b0; enp = 1'b1; wrap = 1'b0; d = 4'd0;
    tick(); tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b0; ld = 1'b1; enp = 1'b1; soma = 1'b1; sub = 1'b0; wrap = 1'b0; d = 4'd0;
    tick(); tick();
    n_checks++; if (q_a !== 2'd0) begin n_errors++; $display("FAIL reset_q: got %0d expected 0", q_a); end
    n_checks++; if (lim_a !== 1'b0) begin n_errors++; $display("FAIL reset_lim: got %0b expected 0", lim_a); end
    clr = 1'b1;
    tick(); tick();
    n_checks++; if (q_a !== 2'd0) begin n_errors++; $display("FAIL reset_held_soma_q: got %0d expected 0", q_a); end
    n_checks++; if (min_a !== 1'b1) begin n_errors++; $display("FAIL reset_at_min: got %0b expected 1", min_a); end
    n_checks++; if (rco_a !== 1'b1) begin n_errors++; $display("FAIL reset_rco_en: got %0b expected 1", rco_a); end
    enp = 1'b0; #1;
    n_checks++; if (rco_a !== 1'b0) begin n_errors++; $display("FAIL reset_rco_dis: got %0b expected 0", rco_a); end
    enp = 1'b1; soma = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_q [4];
    logic       exp_l [4];
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd3};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    wrap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      soma = 1'b1; tick();
      n_checks++; if (q_a !== exp_q[i]) begin n_errors++; $display("FAIL sat_q[%0d]: got %0d expected %0d", i, q_a, exp_q[i]); end
      n_checks++; if (lim_a !== exp_l[i]) begin n_errors++; $display("FAIL sat_lim[%0d]: got %0b expected %0b", i, lim_a, exp_l[i]); end
      soma = 1'b0; tick();
    end
    n_checks++; if (lim_a !== 1'b0) begin n_errors++; $display("FAIL sat_lim_pulse_end: got %0b expected 0", lim_a); end
    n_checks++; if (max_a !== 1'b1) begin n_errors++; $display("FAIL sat_at_max: got %0b expected 1", max_a); end
    wrap = 1'b1; soma = 1'b1; tick();
    n_checks++; if (q_a !== 2'd0) begin n_errors++; $display("FAIL wrap_up_q: got %0d expected 0", q_a); end
    n_checks++; if (lim_a !== 1'b1) begin n_errors++; $display("FAIL wrap_up_lim: got %0b expected 1", lim_a); end
    soma = 1'b0; wrap = 1'b0; tick();
  endtask

  task automatic test_wrap_down();
    logic [3:0] exp_q [4];
    logic       exp_l [4];
    exp_q = '{4'd9, 4'd6, 4'd3, 4'd2};
    exp_l = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    wrap = 1'b1;
    n_checks++; if (q_b !== 4'd2) begin n_errors++; $display("FAIL wdn_start_q: got %0d expected 2", q_b); end
    for (int i = 0; i < 4; i++) begin
      sub = 1'b1; tick();
      n_checks++; if (q_b !== exp_q[i]) begin n_errors++; $display("FAIL wdn_q[%0d]: got %0d expected %0d", i, q_b, exp_q[i]); end
      n_checks++; if (lim_b !== exp_l[i]) begin n_errors++; $display("FAIL wdn_lim[%0d]: got %0b expected %0b", i, lim_b, exp_l[i]); end
      sub = 1'b0; tick();
    end
    n_checks++; if (min_b !== 1'b1) begin n_errors++; $display("FAIL wdn_at_min: got %0b expected 1", min_b); end
    wrap = 1'b0;
  endtask

  task automatic test_auto_repeat();
`ifdef CONTADOR_AUTO_REPEAT_EN
    logic [3:0] exp5 = 4'd2, exp12 = 4'd5;
`else
    logic [3:0] exp5 = 4'd1, exp12 = 4'd1;
`endif
    do_reset();
    soma = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        n_checks++; if (q_c !== 4'd1) begin n_errors++; $display("FAIL rep_c1: got %0d expected 1", q_c); end
      end
      if (c == 4) begin
        n_checks++; if (q_c !== 4'd1) begin n_errors++; $display("FAIL rep_c4: got %0d expected 1", q_c); end
      end
      if (c == 5) begin
        n_checks++; if (q_c !== exp5) begin n_errors++; $display("FAIL rep_c5: got %0d expected %0d", q_c, exp5); end
      end
    end
    n_checks++; if (q_c !== exp12) begin n_errors++; $display("FAIL rep_c12: got %0d expected %0d", q_c, exp12); end
    soma = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (q_c !== exp12) begin n_errors++; $display("FAIL rep_release: got %0d expected %0d", q_c, exp12); end
  endtask

  task automatic test_priority();
    do_reset();
    wrap = 1'b0;
    ld = 1'b0; d = 4'd13; soma = 1'b1; tick();
    n_checks++; if (q_b !== 4'd9) begin n_errors++; $display("FAIL prio_ld_clamp_hi: got %0d expected 9", q_b); end
    n_checks++; if (lim_b !== 1'b0) begin n_errors++; $display("FAIL prio_ld_lim: got %0b expected 0", lim_b); end
    ld = 1'b1; tick();
    n_checks++; if (q_b !== 4'd9) begin n_errors++; $display("FAIL prio_ld_nostep: got %0d expected 9", q_b); end
    soma = 1'b0; tick();
    soma = 1'b1; tick();
    n_checks++; if (lim_b !== 1'b1) begin n_errors++; $display("FAIL prio_idle_press_lim: got %0b expected 1", lim_b); end
    soma = 1'b0; tick();
    ld = 1'b0; d = 4'd0; tick();
    n_checks++; if (q_b !== 4'd2) begin n_errors++; $display("FAIL prio_ld_clamp_lo: got %0d expected 2", q_b); end
    d = 4'd7; tick();
    n_checks++; if (q_b !== 4'd7) begin n_errors++; $display("FAIL prio_ld_plain: got %0d expected 7", q_b); end
    clr = 1'b0; d = 4'd5; tick();
    n_checks++; if (q_b !== 4'd2) begin n_errors++; $display("FAIL prio_clr_over_ld: got %0d expected 2", q_b); end
    clr = 1'b1; ld = 1'b1; tick();
  endtask

  task automatic test_conflicts();
    do_reset();
    soma = 1'b1; sub = 1'b1; tick();
    n_checks++; if (q_a !== 2'd0) begin n_errors++; $display("FAIL conf_both_rise: got %0d expected 0", q_a); end
    soma = 1'b0; sub = 1'b0; tick();
    soma = 1'b1; tick();
    n_checks++; if (q_a !== 2'd1) begin n_errors++; $display("FAIL conf_first_press: got %0d expected 1", q_a); end
    sub = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (q_a !== 2'd1) begin n_errors++; $display("FAIL conf_opposite_hold: got %0d expected 1", q_a); end
    soma = 1'b0; sub = 1'b0; tick();
    enp = 1'b0; soma = 1'b1; tick();
    n_checks++; if (q_a !== 2'd1) begin n_errors++; $display("FAIL conf_enp_low_press: got %0d expected 1", q_a); end
    enp = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (q_a !== 2'd1) begin n_errors++; $display("FAIL conf_enp_late: got %0d expected 1", q_a); end
    soma = 1'b0; tick();
  endtask

  initial begin
    clr = 1'b0; ld = 1'b1; enp = 1'b1; soma = 1'b0; sub = 1'b0; wrap = 1'b0; d = 4'd0;
    test_reset();
    test_saturate();
    test_wrap_down();
    test_auto_repeat();
    test_priority();
    test_conflicts();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
